// File: rtl/flit_demux_1to2.sv
// 1:2 wormhole flit demultiplexer. The head flit's destination picks the output port, and that
// port stays locked until the tail flit. Each port has a registered FIFO with ready/valid
// backpressure. Protocol violations are dropped, flagged on perr and counted.
module flit_demux_1to2 #(
  parameter int         DATAW    = 66,
  parameter int         VCHW     = 2,
  parameter logic [7:0] LOCAL_ID = 8'h04,
  parameter int         DEPTH    = 4,
  parameter int         CNTW     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DATAW-1:0] idata,
  input  logic             ivalid,
  input  logic [VCHW-1:0]  ivch,
  output logic             iready,
  output logic [DATAW-1:0] odata_0,
  output logic             ovalid_0,
  output logic [VCHW-1:0]  ovch_0,
  input  logic             oready_0,
  output logic [DATAW-1:0] odata_1,
  output logic             ovalid_1,
  output logic [VCHW-1:0]  ovch_1,
  input  logic             oready_1,
  output logic             perr,
  output logic [CNTW-1:0]  pkt_cnt_0,
  output logic [CNTW-1:0]  pkt_cnt_1,
  output logic [CNTW-1:0]  err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = VCHW + DATAW;

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
  typedef enum logic [1:0] {FT_NONE = 2'b00, FT_HEAD = 2'b01, FT_TAIL = 2'b10, FT_DATA = 2'b11} ftype_t;

  state_t                         state_q, state_d;
  logic [1:0][DEPTH-1:0][EW-1:0]  mem_q, mem_d;
  logic [1:0][AW:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0][CNTW-1:0]           pkt_cnt_q, pkt_cnt_d;
  logic [CNTW-1:0]                err_cnt_q, err_cnt_d;
  logic                           perr_q, perr_d;

  ftype_t     ftype;
  logic       route;
  logic       lock_port;
  logic [1:0] oready_v, empty, full, pop, can_push, push;

  // Decode the incoming flit and derive per-FIFO status; a full FIFO that pops this cycle can take a push.
  always_comb begin
    ftype     = ftype_t'(idata[DATAW-1 -: 2]);
    route     = (idata[7:0] != LOCAL_ID);
    lock_port = (state_q == LOCK1);
    oready_v  = {oready_1, oready_0};
    for (int unsigned p = 0; p < 2; p++) begin
      empty[p]    = (wr_ptr_q[p] == rd_ptr_q[p]);
      full[p]     = (wr_ptr_q[p][AW] != rd_ptr_q[p][AW]) &&
                    (wr_ptr_q[p][AW-1:0] == rd_ptr_q[p][AW-1:0]);
      pop[p]      = !empty[p] && oready_v[p];
      can_push[p] = !full[p] || pop[p];
    end
  end

  // Input ready depends on flit type/destination and FIFO space only, never on ivalid.
  always_comb begin
    iready = 1'b0;
    case (state_q)
      IDLE:         iready = (ftype == FT_HEAD) ? can_push[route] : 1'b1;
      LOCK0, LOCK1: iready = can_push[lock_port];
      default:      iready = 1'b0;
    endcase
  end

  // Routing FSM: lock on head, forward data, release on tail; illegal flits are dropped and counted.
  always_comb begin
    state_d   = state_q;
    push      = '0;
    perr_d    = 1'b0;
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (ivalid && iready) begin
      case (state_q)
        IDLE: begin
          if (ftype == FT_HEAD) begin
            push[route] = 1'b1;
            state_d     = route ? LOCK1 : LOCK0;
          end else if (ftype != FT_NONE) begin
            perr_d = 1'b1;
          end
        end
        LOCK0, LOCK1: begin
          case (ftype)
            FT_HEAD: perr_d = 1'b1;
            FT_DATA: push[lock_port] = 1'b1;
            FT_TAIL: begin
              push[lock_port]      = 1'b1;
              pkt_cnt_d[lock_port] = pkt_cnt_q[lock_port] + CNTW'(1);
              state_d              = IDLE;
            end
            default: ;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
    if (perr_d) err_cnt_d = err_cnt_q + CNTW'(1);
  end

  // FIFO pointer advance and storage write of {vch, data}.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int unsigned p = 0; p < 2; p++) begin
      wr_ptr_d[p] = wr_ptr_q[p] + {{AW{1'b0}}, push[p]};
      rd_ptr_d[p] = rd_ptr_q[p] + {{AW{1'b0}}, pop[p]};
      if (push[p]) mem_d[p][wr_ptr_q[p][AW-1:0]] = {ivch, idata};
    end
  end

  // State, FIFO and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
      perr_q    <= perr_d;
    end
  end

  // FIFO heads drive the outputs; an empty FIFO presents zeros.
  assign ovalid_0  = !empty[0];
  assign ovalid_1  = !empty[1];
  assign odata_0   = empty[0] ? '0 : mem_q[0][rd_ptr_q[0][AW-1:0]][DATAW-1:0];
  assign ovch_0    = empty[0] ? '0 : mem_q[0][rd_ptr_q[0][AW-1:0]][EW-1:DATAW];
  assign odata_1   = empty[1] ? '0 : mem_q[1][rd_ptr_q[1][AW-1:0]][DATAW-1:0];
  assign ovch_1    = empty[1] ? '0 : mem_q[1][rd_ptr_q[1][AW-1:0]][EW-1:DATAW];
  assign perr      = perr_q;
  assign pkt_cnt_0 = pkt_cnt_q[0];
  assign pkt_cnt_1 = pkt_cnt_q[1];
  assign err_cnt   = err_cnt_q;

endmodule
